// File: rtl/alu_op_pkg.sv
// Shared RV32I decode types: ALU ops, operand selects, opcodes and the
// decode-to-execute control bundle.
package alu_op_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_t     alu_op;
        a_sel_t      a_sel;
        logic        b_sel;
        logic [4:0]  shamt;
        logic        shamt_sel;
        logic        branch;
        logic [2:0]  branch_type;
        logic        jump;
        logic        jalr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  mem_size;
        logic        illegal;
    } dec_bundle_t;

    // alt selects SUB/SRA; SUB only exists for register-register ops
    function automatic alu_op_t f3_alu_op(
        input logic [2:0] f3,
        input logic       alt,
        input logic       sub_ok
    );
        alu_op_t op;
        op = ALU_ADD;
        unique case (f3)
            3'b000: op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshakes of the decode stage.
interface instr_decode_stage_if;
    import alu_op_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    alu_op_t     out_alu_op;
    a_sel_t      out_a_sel;
    logic        out_b_sel;
    logic [4:0]  out_shamt;
    logic        out_shamt_sel;
    logic        out_branch;
    logic [2:0]  out_branch_type;
    logic        out_jump;
    logic        out_jalr;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [2:0]  out_mem_size;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc,
        output out_rs1, out_rs2, out_rd, out_imm,
        output out_alu_op, out_a_sel, out_b_sel,
        output out_shamt, out_shamt_sel,
        output out_branch, out_branch_type,
        output out_jump, out_jalr, out_reg_write,
        output out_mem_read, out_mem_write,
        output out_mem_size, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc,
        input  out_rs1, out_rs2, out_rd, out_imm,
        input  out_alu_op, out_a_sel, out_b_sel,
        input  out_shamt, out_shamt_sel,
        input  out_branch, out_branch_type,
        input  out_jump, out_jalr, out_reg_write,
        input  out_mem_read, out_mem_write,
        input  out_mem_size, out_illegal
    );

endinterface

// File: rtl/instr_decode_stage_skid_buffer.sv
// Two-entry skid buffer: registered in_ready, in-order, flush kills both.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_v;
    logic         skid_v;
    logic [W-1:0] main_d;
    logic [W-1:0] skid_d;
    logic         drain;
    logic         take;

    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign drain     = main_v && out_ready;
    assign take      = in_valid && !skid_v && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v && drain) begin
            // skid full means no accept this cycle; main stays valid
            main_d <= skid_d;
            skid_v <= 1'b0;
        end else if (take && (!main_v || drain)) begin
            main_v <= 1'b1;
            main_d <= in_data;
        end else if (take) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
        end else if (drain) begin
            main_v <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: combinational decode into a control bundle,
// buffered behind a two-entry skid buffer.
module instr_decode_stage
    import alu_op_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic clk,
    input logic rst_n,
    instr_decode_stage_if.slave bus
);

    localparam int BW = $bits(dec_bundle_t);

    logic [31:0]     ins;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic            ill;
    logic            wr;
    dec_bundle_t     d;
    dec_bundle_t     q;
    logic [BW-1:0]   q_raw;

    assign ins = bus.in_instr;
    assign opc = ins[6:0];
    assign f3  = ins[14:12];

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                    ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                    ins[20], ins[30:21], 1'b0};

    always_comb begin
        d           = '0;
        d.pc        = bus.in_pc;
        d.rs1       = ins[19:15];
        d.rs2       = ins[24:20];
        d.rd        = ins[11:7];
        d.shamt     = ins[24:20];
        d.alu_op    = ALU_ADD;
        d.a_sel     = A_RS1;
        ill         = 1'b0;
        wr          = 1'b0;
        unique case (1'b1)
            opc == OPC_OP: begin
                d.alu_op    = f3_alu_op(f3, ins[30], 1'b1);
                d.shamt_sel = 1'b1;
                wr          = 1'b1;
            end
            opc == OPC_OP_IMM: begin
                d.alu_op = f3_alu_op(f3, ins[30], 1'b0);
                d.b_sel  = 1'b1;
                d.imm    = imm_i;
                wr       = 1'b1;
            end
            opc == OPC_BRANCH: begin
                d.alu_op      = ALU_SUB;
                d.branch      = 1'b1;
                d.branch_type = f3;
                d.imm         = imm_b;
                ill           = (f3 == 3'b010) || (f3 == 3'b011);
            end
            opc == OPC_LOAD: begin
                d.b_sel    = 1'b1;
                d.imm      = imm_i;
                d.mem_read = 1'b1;
                d.mem_size = f3;
                wr         = 1'b1;
            end
            opc == OPC_STORE: begin
                d.b_sel     = 1'b1;
                d.imm       = imm_s;
                d.mem_write = 1'b1;
                d.mem_size  = f3;
            end
            opc == OPC_LUI: begin
                d.a_sel = A_ZERO;
                d.b_sel = 1'b1;
                d.imm   = imm_u;
                wr      = 1'b1;
            end
            opc == OPC_AUIPC: begin
                d.a_sel = A_PC;
                d.b_sel = 1'b1;
                d.imm   = imm_u;
                wr      = 1'b1;
            end
            opc == OPC_JAL: begin
                d.jump  = 1'b1;
                d.a_sel = A_PC;
                d.b_sel = 1'b1;
                d.imm   = imm_j;
                wr      = 1'b1;
            end
            opc == OPC_JALR: begin
                d.jump  = 1'b1;
                d.jalr  = 1'b1;
                d.b_sel = 1'b1;
                d.imm   = imm_i;
                wr      = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // still delivered so execute can raise the trap
        if (ill) begin
            d.illegal   = 1'b1;
            d.alu_op    = ALU_ADD;
            d.branch    = 1'b0;
            d.jump      = 1'b0;
            d.jalr      = 1'b0;
            d.mem_read  = 1'b0;
            d.mem_write = 1'b0;
            wr          = 1'b0;
        end
        d.reg_write = wr && (d.rd != 5'd0);
    end

    skid_buffer #(
        .W(BW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.flush),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .in_data  (d),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready),
        .out_data (q_raw)
    );

    assign q = dec_bundle_t'(q_raw);

    assign bus.out_pc          = q.pc;
    assign bus.out_rs1         = q.rs1;
    assign bus.out_rs2         = q.rs2;
    assign bus.out_rd          = q.rd;
    assign bus.out_imm         = q.imm;
    assign bus.out_alu_op      = q.alu_op;
    assign bus.out_a_sel       = q.a_sel;
    assign bus.out_b_sel       = q.b_sel;
    assign bus.out_shamt       = q.shamt;
    assign bus.out_shamt_sel   = q.shamt_sel;
    assign bus.out_branch      = q.branch;
    assign bus.out_branch_type = q.branch_type;
    assign bus.out_jump        = q.jump;
    assign bus.out_jalr        = q.jalr;
    assign bus.out_reg_write   = q.reg_write;
    assign bus.out_mem_read    = q.mem_read;
    assign bus.out_mem_write   = q.mem_write;
    assign bus.out_mem_size    = q.mem_size;
    assign bus.out_illegal     = q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: decode vectors, backpressure,
// flush and asynchronous reset.
module tb_instr_decode_stage;
    import alu_op_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_out = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    instr_decode_stage_if bus();

    instr_decode_stage #(
        .XLEN(32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    dec_bundle_t obs;

    always_comb begin
        obs             = '0;
        obs.pc          = bus.out_pc;
        obs.rs1         = bus.out_rs1;
        obs.rs2         = bus.out_rs2;
        obs.rd          = bus.out_rd;
        obs.imm         = bus.out_imm;
        obs.alu_op      = bus.out_alu_op;
        obs.a_sel       = bus.out_a_sel;
        obs.b_sel       = bus.out_b_sel;
        obs.shamt       = bus.out_shamt;
        obs.shamt_sel   = bus.out_shamt_sel;
        obs.branch      = bus.out_branch;
        obs.branch_type = bus.out_branch_type;
        obs.jump        = bus.out_jump;
        obs.jalr        = bus.out_jalr;
        obs.reg_write   = bus.out_reg_write;
        obs.mem_read    = bus.out_mem_read;
        obs.mem_write   = bus.out_mem_write;
        obs.mem_size    = bus.out_mem_size;
        obs.illegal     = bus.out_illegal;
    end

    task automatic chk(
        input string        tag,
        input logic [127:0] got,
        input logic [127:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] v_ins [9];
    dec_bundle_t v_exp [9];
    string       v_nm  [9];

    function automatic dec_bundle_t base(
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd,
        input logic [31:0] imm
    );
        dec_bundle_t b;
        b        = '0;
        b.rs1    = rs1;
        b.rs2    = rs2;
        b.rd     = rd;
        b.imm    = imm;
        b.shamt  = rs2;
        b.alu_op = ALU_ADD;
        b.a_sel  = A_RS1;
        return b;
    endfunction

    task automatic init_vecs();
        v_nm[0] = "add";  v_ins[0] = 32'h002081B3;
        v_exp[0] = base(5'd1, 5'd2, 5'd3, 32'h0);
        v_exp[0].shamt_sel = 1'b1;
        v_exp[0].reg_write = 1'b1;

        v_nm[1] = "sub";  v_ins[1] = 32'h402081B3;
        v_exp[1] = base(5'd1, 5'd2, 5'd3, 32'h0);
        v_exp[1].alu_op    = ALU_SUB;
        v_exp[1].shamt_sel = 1'b1;
        v_exp[1].reg_write = 1'b1;

        v_nm[2] = "srai"; v_ins[2] = 32'h40335293;
        v_exp[2] = base(5'd6, 5'd3, 5'd5, 32'h403);
        v_exp[2].alu_op    = ALU_SRA;
        v_exp[2].b_sel     = 1'b1;
        v_exp[2].reg_write = 1'b1;

        v_nm[3] = "bne";  v_ins[3] = 32'hFE209EE3;
        v_exp[3] = base(5'd1, 5'd2, 5'd29, 32'hFFFFFFFC);
        v_exp[3].alu_op      = ALU_SUB;
        v_exp[3].branch      = 1'b1;
        v_exp[3].branch_type = 3'b001;

        v_nm[4] = "ill0"; v_ins[4] = 32'h00000000;
        v_exp[4] = base(5'd0, 5'd0, 5'd0, 32'h0);
        v_exp[4].illegal = 1'b1;

        v_nm[5] = "lui";  v_ins[5] = 32'h123453B7;
        v_exp[5] = base(5'd8, 5'd3, 5'd7, 32'h12345000);
        v_exp[5].a_sel     = A_ZERO;
        v_exp[5].b_sel     = 1'b1;
        v_exp[5].reg_write = 1'b1;

        v_nm[6] = "lw";   v_ins[6] = 32'h00812203;
        v_exp[6] = base(5'd2, 5'd8, 5'd4, 32'h8);
        v_exp[6].b_sel     = 1'b1;
        v_exp[6].mem_read  = 1'b1;
        v_exp[6].mem_size  = 3'b010;
        v_exp[6].reg_write = 1'b1;

        v_nm[7] = "sw";   v_ins[7] = 32'hFE50AE23;
        v_exp[7] = base(5'd1, 5'd5, 5'd28, 32'hFFFFFFFC);
        v_exp[7].b_sel     = 1'b1;
        v_exp[7].mem_write = 1'b1;
        v_exp[7].mem_size  = 3'b010;

        v_nm[8] = "jal";  v_ins[8] = 32'h010000EF;
        v_exp[8] = base(5'd0, 5'd16, 5'd1, 32'd16);
        v_exp[8].jump      = 1'b1;
        v_exp[8].a_sel     = A_PC;
        v_exp[8].b_sel     = 1'b1;
        v_exp[8].reg_write = 1'b1;
    endtask

    function automatic dec_bundle_t exp_at(input int i, input logic [31:0] pc);
        dec_bundle_t b;
        b    = v_exp[i];
        b.pc = pc;
        return b;
    endfunction

    dec_bundle_t sbq [$];
    string       snq [$];
    dec_bundle_t drv_exp;
    string       drv_nm;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            snq.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sbq.size() == 0)
                    chk("sb_underflow", 128'(sbq.size()), 128'd1);
                else
                    chk({"out_", snq.pop_front()}, obs, sbq.pop_front());
            end
            if (bus.flush) begin
                sbq.delete();
                snq.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                sbq.push_back(drv_exp);
                snq.push_back(drv_nm);
            end
        end
    end

    task automatic offer(input int i, input logic [31:0] pc);
        bus.in_instr = v_ins[i];
        bus.in_pc    = pc;
        drv_exp      = exp_at(i, pc);
        drv_nm       = v_nm[i];
        bus.in_valid = 1'b1;
    endtask

    task automatic send(input int i, input logic [31:0] pc);
        logic hs;
        hs = 1'b0;
        offer(i, pc);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
            if (hs) break;
        end
        if (!hs) chk("send_timeout", 128'(hs), 128'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((sbq.size() != 0 || bus.out_valid) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", 128'(k < 50), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int n0;
        init_vecs();
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drv_exp       = '0;
        drv_nm        = "none";

        #2;
        chk("rst_out_valid", bus.out_valid, 128'd0);
        chk("rst_in_ready", bus.in_ready, 128'd1);
        chk("rst_bundle", obs, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(0, 32'h100);
        chk("lat_valid", bus.out_valid, 128'd1);
        chk("lat_bundle", obs, exp_at(0, 32'h100));

        c0 = cyc;
        for (int i = 1; i < 9; i++) send(i, 32'h200 + 32'(4 * i));
        chk("throughput", 128'(cyc - c0), 128'd8);
        wait_drain();

        bus.out_ready = 1'b0;
        send(0, 32'h300);
        chk("bp_ready_1", bus.in_ready, 128'd1);
        send(1, 32'h304);
        chk("bp_ready_0", bus.in_ready, 128'd0);
        offer(2, 32'h308);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", bus.in_ready, 128'd0);
            chk("bp_stable", obs, exp_at(0, 32'h300));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(2, 32'h308);
        wait_drain();

        bus.out_ready = 1'b0;
        send(3, 32'h400);
        send(4, 32'h404);
        offer(5, 32'h408);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_out_valid", bus.out_valid, 128'd0);
        chk("fl_in_ready", bus.in_ready, 128'd1);
        n0 = n_out;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("fl_no_stale", 128'(n_out), 128'(n0));

        bus.out_ready = 1'b0;
        send(5, 32'h500);
        send(6, 32'h504);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", bus.out_valid, 128'd0);
        chk("ar_in_ready", bus.in_ready, 128'd1);
        chk("ar_bundle", obs, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        n0 = n_out;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ar_no_stale", 128'(n_out), 128'(n0));
        send(7, 32'h600);
        wait_drain();
        chk("ar_one_out", 128'(n_out), 128'(n0 + 1));
        chk("sb_left", 128'(sbq.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
